// File: rtl/xor_result_sink_pkg.sv
// Shared definitions for the word-serial result sink: HQC size lookup,
// buffer geometry helpers and FSM state encoding.
`default_nettype none

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package xor_result_sink_pkg;

  localparam int N_HQC128 = 17669;
  localparam int N_HQC192 = 35851;
  localparam int N_HQC256 = 57637;

  // Polynomial length rounded up to a whole number of words.
  function automatic int n_mem_of(input int n, input int width);
    return n + (width - n % width) % width;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/xor_result_sink_buffer_ram.sv
// Simple dual-port DEPTH x WIDTH buffer: one write port, one registered
// read-first read port; out-of-range reads return zero.
`default_nettype none

module sink_buffer_ram #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 139,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Separate process keeps the array free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (rd_addr < DEPTH_A) ? mem[rd_addr] : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/xor_result_sink.sv
// Capture sink for a streamed polynomial result with ordering/completeness
// checks and a registered read port. Optional macro: SINK_TAIL_MASK_EN.
`default_nettype none

module xor_result_sink
  import xor_result_sink_pkg::*;
#(
  parameter PARAMETER_SET = "hqc256",
  parameter int WIDTH     = 128,
  localparam int N        = (PARAMETER_SET == "hqc128") ? N_HQC128 :
                            (PARAMETER_SET == "hqc192") ? N_HQC192 : N_HQC256,
  localparam int N_MEM    = n_mem_of(N, WIDTH),
  localparam int DEPTH    = N_MEM / WIDTH,
  localparam int LOG_DEPTH = `CLOG2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [LOG_DEPTH-1:0] in_addr,
  input  logic                 in_valid,
  input  logic                 in_done,
  input  logic                 rd_en,
  input  logic [LOG_DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 busy,
  output logic                 complete,
  output logic                 result_valid,
  output logic                 err_order,
  output logic                 err_short,
  output logic [LOG_DEPTH-1:0] word_count
);

  localparam logic [LOG_DEPTH-1:0] DEPTH_W = LOG_DEPTH'(DEPTH);
  localparam logic [LOG_DEPTH-1:0] LAST_W  = LOG_DEPTH'(DEPTH - 1);

  state_t state, state_next;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;

  // Addresses at or beyond DEPTH are the producer's over-read and are dropped.
  assign wr_en = (state == S_CAPTURE) && in_valid && (in_addr < DEPTH_W);

`ifdef SINK_TAIL_MASK_EN
  localparam int TAIL = N % WIDTH;
  localparam logic [WIDTH-1:0] TAIL_MASK =
      (TAIL == 0) ? {WIDTH{1'b1}} : ({WIDTH{1'b1}} >> (WIDTH - TAIL));

  assign wr_data = (in_addr == LAST_W) ? (in_data & TAIL_MASK) : in_data;
`else
  assign wr_data = in_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    complete   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy = 1'b1;
        if (in_done) state_next = S_DONE;
      end
      S_DONE: begin
        complete   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_count   <= '0;
      err_order    <= 1'b0;
      err_short    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            word_count   <= '0;
            err_order    <= 1'b0;
            err_short    <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (wr_en) begin
            if (in_addr != word_count) err_order <= 1'b1;
            if (word_count != DEPTH_W) word_count <= word_count + 1'b1;
          end
        end
        S_DONE: begin
          result_valid <= 1'b1;
          err_short    <= (word_count != DEPTH_W);
        end
        default: ;
      endcase
    end
  end

  sink_buffer_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (LOG_DEPTH)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (in_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_xor_result_sink.sv
// Randomised self-checking bench for xor_result_sink (hqc128 geometry)
// against a cycle-level behavioural model of the sink's rules.
`default_nettype none

module tb_xor_result_sink;

  localparam int W  = 128;
  localparam int D  = 139;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_done, rd_en;
  logic [W-1:0]  in_data;
  logic [AW-1:0] in_addr, rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy, complete, result_valid, err_order, err_short;
  logic [AW-1:0] word_count;

  xor_result_sink #(.PARAMETER_SET("hqc128"), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_addr(in_addr),
    .in_valid(in_valid), .in_done(in_done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .complete(complete),
    .result_valid(result_valid), .err_order(err_order), .err_short(err_short),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;
  bit noise = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rep(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {16{b}};
  endfunction

  // Value the buffer must hold after a write of d to address a.
  function automatic logic [W-1:0] stored(input int a, input logic [W-1:0] d);
`ifdef SINK_TAIL_MASK_EN
    if (a == D - 1) return d & {{(W-5){1'b0}}, 5'h1F};
`endif
    return d;
  endfunction

  // ---------------- behavioural model ----------------
  int           m_phase;   // 0 idle, 1 capturing, 2 finishing
  int           m_count;
  bit           m_order, m_short, m_rv;
  logic [W-1:0] m_mem [D];
  bit           m_known [D];
  logic [W-1:0] m_rd;
  bit           m_rd_known;

  initial begin
    for (int i = 0; i < D; i++) m_known[i] = 0;
    m_phase = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_count = 0; m_order = 0; m_short = 0; m_rv = 0;
      m_rd = '0; m_rd_known = 1;
    end else begin
      if (rd_en) begin
        if (int'(rd_addr) >= D) begin
          m_rd = '0; m_rd_known = 1;
        end else begin
          m_rd = m_mem[rd_addr]; m_rd_known = m_known[rd_addr];
        end
      end
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1; m_count = 0; m_order = 0; m_short = 0; m_rv = 0;
        end
      end else if (m_phase == 1) begin
        if (in_valid && int'(in_addr) < D) begin
          if (int'(in_addr) != m_count) m_order = 1;
          m_mem[in_addr]   = stored(int'(in_addr), in_data);
          m_known[in_addr] = 1;
          m_count = (m_count < D) ? m_count + 1 : D;
        end
        if (in_done) m_phase = 2;
      end else begin
        m_rv = 1; m_short = (m_count != D); m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",         W'(busy),         W'(m_phase == 1));
      chk("complete",     W'(complete),     W'(m_phase == 2));
      chk("result_valid", W'(result_valid), W'(m_rv));
      chk("err_order",    W'(err_order),    W'(m_order));
      chk("err_short",    W'(err_short),    W'(m_short));
      chk("word_count",   W'(word_count),   W'(m_count));
      if (m_rd_known) chk("rd_data", rd_data, m_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    start = 0; in_valid = 0; in_done = 0; rd_en = 0;
    in_data = $urandom(); in_addr = AW'($urandom_range(0, 255));
    rd_addr = AW'($urandom_range(0, 255));
  endtask

  task automatic send(input bit v, input int a, input logic [W-1:0] d, input bit done);
    in_valid = v; in_addr = AW'(a); in_data = d; in_done = done;
    rd_en = ($urandom_range(0, 3) == 0);
    rd_addr = AW'($urandom_range(0, 145));
    if (noise) start = ($urandom_range(0, 15) == 0);
    tick();
  endtask

  task automatic do_start();
    start = 1;
    tick();
  endtask

  task automatic read(input int a);
    rd_en = 1; rd_addr = AW'(a);
    tick();
  endtask

  task automatic finish_capture();
    in_done = 1;
    tick();
    chk("complete pulse", W'(complete), W'(1));
    tick();
    chk("complete single", W'(complete), W'(0));
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; in_done = 0; rd_en = 0;
    in_data = '0; in_addr = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", W'(busy), W'(0));
    chk("reset rd_data", rd_data, '0);
    chk("reset word_count", W'(word_count), W'(0));
    rst = 0;
    chk_en = 1;
    tick();

    // Nominal in-order capture, including trailing over-read at addr D.
    do_start();
    for (int i = 0; i <= D; i++) send(1, i, rep(i), 0);
    finish_capture();
    chk("nom result_valid", W'(result_valid), W'(1));
    chk("nom word_count", W'(word_count), W'(139));
    chk("nom err_order", W'(err_order), W'(0));
    chk("nom err_short", W'(err_short), W'(0));
    read(10);
    chk("nom read 10", rd_data, {16{8'h0A}});
    read(200);
    chk("read out of range", rd_data, '0);

    // Out-of-order: 0,1,3,2,4.. with random data.
    do_start();
    send(1, 0, {4{$urandom()}}, 0);
    send(1, 1, {4{$urandom()}}, 0);
    send(1, 3, {4{$urandom()}}, 0);
    chk("ooo err_order set", W'(err_order), W'(1));
    send(1, 2, {4{$urandom()}}, 0);
    for (int i = 4; i < D; i++) send(1, i, {4{$urandom()}}, 0);
    finish_capture();
    chk("ooo err_order held", W'(err_order), W'(1));

    // Short stream.
    do_start();
    for (int i = 0; i < 100; i++) send(1, i, rep(i), 0);
    finish_capture();
    chk("short err_short", W'(err_short), W'(1));
    chk("short word_count", W'(word_count), W'(100));
    chk("short result_valid", W'(result_valid), W'(1));

    // Same-cycle read/write at 5 returns old data; last write coincides with done.
    do_start();
    for (int i = 0; i < D - 1; i++) begin
      if (i == 5) begin
        rd_en = 1; rd_addr = 8'd5;
        in_valid = 1; in_addr = 8'd5; in_data = ~rep(5);
        tick();
        chk("read-first 5", rd_data, {16{8'h05}});
      end else begin
        send(1, i, ~rep(i), 0);
      end
    end
    in_valid = 1; in_addr = 8'd138; in_data = ~rep(138);
    finish_capture();
    chk("sim err_short", W'(err_short), W'(0));
    read(138);
`ifdef SINK_TAIL_MASK_EN
    chk("sim read 138", rd_data, {123'd0, 5'h15});
`else
    chk("sim read 138", rd_data, {16{8'h75}});
`endif

    // Reset in the middle of a capture.
    do_start();
    for (int i = 0; i <= 60; i++) send(1, i, {4{$urandom()}}, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("mid rst busy", W'(busy), W'(0));
    chk("mid rst result_valid", W'(result_valid), W'(0));
    chk("mid rst err_order", W'(err_order), W'(0));
    chk("mid rst word_count", W'(word_count), W'(0));
    do_start();
    for (int i = 0; i < D; i++) send(1, i, (i == D - 1) ? '1 : {4{$urandom()}}, 0);
    finish_capture();
    chk("recap err_order", W'(err_order), W'(0));
    chk("recap result_valid", W'(result_valid), W'(1));
    read(138);
`ifdef SINK_TAIL_MASK_EN
    chk("tail mask", rd_data, {123'd0, 5'h1F});
`else
    chk("tail unmasked", rd_data, '1);
`endif

    // Randomised captures: gaps, duplicates, over-reads, ignored start/idle traffic.
    for (int r = 0; r < 6; r++) begin
      noise = 0;
      for (int k = 0; k < 3; k++) send($urandom_range(0, 1), $urandom_range(0, 145), {4{$urandom()}}, $urandom_range(0, 1));
      do_start();
      noise = 1;
      for (int i = 0; i < $urandom_range(80, 180); i++) begin
        int a;
        a = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 145) : (i % 150);
        send($urandom_range(0, 7) != 0, a, {4{$urandom()}}, 0);
      end
      noise = 0;
      in_valid = $urandom_range(0, 1); in_addr = AW'($urandom_range(0, 140)); in_data = {4{$urandom()}};
      finish_capture();
      for (int k = 0; k < 8; k++) read($urandom_range(0, 145));
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/xor_result_sink.md
Name: xor_result_sink

Overview:
- Receiving end of the streamed result interface driven by the XOR adder and similar word-serial producers: data word, address, valid and done.
- Captures one full polynomial (DEPTH words of WIDTH bits) into an internal buffer and checks stream ordering and completeness.
- Exposes a registered read port for downstream consumers (encoder/decoder stages, output serialiser).
- Sits between an arithmetic stage and the next stage's operand fetch.

Parameters:
- parameter_set, "hqc256", selects N: hqc128 = 17669, hqc192 = 35851, hqc256 = 57637.
- WIDTH, 128, word width in bits.
- N_MEM, N + (WIDTH - N%WIDTH)%WIDTH, padded polynomial length.
- DEPTH, N_MEM/WIDTH, number of buffer words.
- LOG_DEPTH, CLOG2(DEPTH+1), address width; must be able to represent DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  arms capture of a new polynomial.
- in_data  in  WIDTH  streamed result word.
- in_addr  in  LOG_DEPTH  word index of in_data.
- in_valid  in  1  in_data/in_addr valid this cycle.
- in_done  in  1  producer finished; single-cycle pulse.
- rd_en  in  1  read request.
- rd_addr  in  LOG_DEPTH  read word index.
- rd_data  out  WIDTH  read data, one cycle after rd_en.
- busy  out  1  high while in S_CAPTURE.
- complete  out  1  one-cycle pulse when capture ends.
- result_valid  out  1  level; buffer holds a finished capture.
- err_order  out  1  sticky: a word arrived out of sequence.
- err_short  out  1  set at done if fewer than DEPTH words were captured.
- word_count  out  LOG_DEPTH  words written in the current capture.

Behaviour:
- Reset values: all outputs 0; state S_IDLE. Buffer contents are not cleared.
- S_IDLE:
  - busy = 0.
  - start → S_CAPTURE next cycle. On that transition: clear word_count, err_order, err_short and result_valid.
  - in_valid and in_done are ignored.
- S_CAPTURE:
  - busy = 1.
  - in_valid with in_addr < DEPTH: write mem[in_addr] <= in_data; word_count + 1.
  - If in_addr != word_count on that write, set err_order (sticky until next start).
  - in_valid with in_addr >= DEPTH (the producer's trailing over-read word at addr DEPTH): discarded silently; no count change, no error.
  - in_done → S_DONE. If in_valid is also high in that cycle, the write is performed first.
  - start is ignored.
- S_DONE, one cycle:
  - complete = 1; result_valid <= 1.
  - err_short <= (word_count != DEPTH).
  - → S_IDLE.
- Read port:
  - Available in every state. rd_data is registered with latency 1 and holds its value when rd_en = 0.
  - Read-first: reading an address written in the same cycle returns the old data.
  - rd_addr >= DEPTH returns all-zero.
- Reset mid-capture: return to S_IDLE, flags cleared, partial buffer contents kept but result_valid = 0.
- word_count saturates at DEPTH. Duplicate addresses still increment it up to saturation and trip err_order.

Optional Feature:
- Macro SINK_TAIL_MASK_EN.
- Defined: bits at index >= N%WIDTH of the word written to address DEPTH-1 are forced to 0 before storage, so the padding is guaranteed clean. Not applied when N%WIDTH == 0.
- Undefined: words are stored unmodified.

Decomposition:
- Shared package/header: parameter_set → N lookup, N_MEM/DEPTH/LOG_DEPTH derivations, CLOG2 macro, state encodings S_IDLE=0, S_CAPTURE=1, S_DONE=2.
- One sub-module, sink_buffer_ram: simple dual-port DEPTH×WIDTH RAM with a write port and a registered read-first read port. It must infer block RAM.

Test Plan (parameter_set = "hqc128": DEPTH = 139, LOG_DEPTH = 8, N%WIDTH = 5):
- Nominal capture: start; stream addrs 0..139 in order with data = {addr replicated}; then in_done → complete pulses once, result_valid = 1, word_count = 139, err_order = 0, err_short = 0; reading addr 10 returns word 10 after 1 cycle.
- Out-of-order: stream 0,1,3,2,... → err_order = 1 after the addr-3 write and stays set through complete; data lands at the correct addresses.
- Short stream: only addrs 0..99, then in_done → err_short = 1, word_count = 100, result_valid = 1.
- Simultaneous events: in_valid at addr 138 in the same cycle as in_done → word 138 stored, complete on the next cycle. A read of addr 5 in the same cycle as a write to addr 5 returns the old value.
- Reset mid-capture at addr 60 → busy = 0, result_valid = 0, all flags 0. A new start then captures cleanly.
- SINK_TAIL_MASK_EN: write all-ones to addr 138 → readback 0x1F with the macro defined; all-ones without it.
